ps2_receiver: RTL and testbench

PS2_RECEIVER -- requirements
Module: ps2_receiver

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_sync_filter.sv | 47 ++++
 rtl/ps2_receiver.sv | 177 +++++++++++++++++
 tb/tb_ps2_receiver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam int         DATA_BITS  = 8;
  localparam int         BIT_CNT_W  = $clog2(DATA_BITS + 1);

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchroniser plus run-length glitch filter for the PS/2 clock line.
// fall_edge is a combinational strobe, valid only in the clk_en cycle in
// which the filtered level drops, so the caller can sample data alongside it.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic raw,
  output logic fall_edge
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          s1;
  logic          s2;
  logic          level;
  logic [FW-1:0] run_cnt;
  logic          hit;

  assign hit       = clk_en && (s2 != level) && (run_cnt == FW'(FILTER_LEN - 1));
  assign fall_edge = hit && !s2;

  // Two-flop synchroniser and filtered level; everything idles high so reset
  // never produces an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      level   <= 1'b1;
      run_cnt <= '0;
    end else if (clk_en) begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        run_cnt <= '0;
      end else if (hit) begin
        level   <= s2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: frames bytes off the bus, folds E0/F0 prefixes
// into flags and presents one scan code per valid pulse.
//
// state  | meaning
// IDLE   | bus idle, waiting for a start bit (data low on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then back to IDLE
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 3,
  parameter int TIMEOUT    = 2000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       clk_en,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] code,
  output logic       released,
  output logic       extended,
  output logic       valid,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  ps2_state_t           state, state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [7:0]           shift_q, shift_nxt;
  logic                 par_q, par_nxt;
  logic [TW-1:0]        tmo_q, tmo_nxt;
  logic                 ext_pend, ext_pend_nxt;
  logic                 brk_pend, brk_pend_nxt;
  logic                 byte_ok, byte_ok_nxt;
  logic [7:0]           code_nxt;
  logic                 released_nxt, extended_nxt, valid_nxt, error_nxt;
  logic                 data_s1, data_s2;
  logic                 fall_edge;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk       (clk),
    .rst       (RESET),
    .clk_en    (clk_en),
    .raw       (PS2_CLK),
    .fall_edge (fall_edge)
  );

  // Data line only needs synchronising; it is sampled on filtered clock edges.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else if (clk_en) begin
      data_s1 <= PS2_DATA;
      data_s2 <= data_s1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      byte_ok  <= 1'b0;
      code     <= 8'h00;
      released <= 1'b0;
      extended <= 1'b0;
      valid    <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift_q  <= shift_nxt;
      par_q    <= par_nxt;
      tmo_q    <= tmo_nxt;
      ext_pend <= ext_pend_nxt;
      brk_pend <= brk_pend_nxt;
      byte_ok  <= byte_ok_nxt;
      code     <= code_nxt;
      released <= released_nxt;
      extended <= extended_nxt;
      valid    <= valid_nxt;
      error    <= error_nxt;
    end
  end

  // Frame FSM, timeout and prefix handling; a good byte is delivered one clk
  // after its stop edge so valid and error can never coincide.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_q;
    par_nxt      = par_q;
    tmo_nxt      = tmo_q;
    ext_pend_nxt = ext_pend;
    brk_pend_nxt = brk_pend;
    byte_ok_nxt  = 1'b0;
    code_nxt     = code;
    released_nxt = released;
    extended_nxt = extended;
    valid_nxt    = 1'b0;
    error_nxt    = 1'b0;

    if (byte_ok) begin
      if (shift_q == PREFIX_EXT) begin
        ext_pend_nxt = 1'b1;
      end else if (shift_q == PREFIX_BRK) begin
        brk_pend_nxt = 1'b1;
      end else begin
        code_nxt     = shift_q;
        released_nxt = brk_pend;
        extended_nxt = ext_pend;
        valid_nxt    = 1'b1;
        ext_pend_nxt = 1'b0;
        brk_pend_nxt = 1'b0;
      end
    end

    if (clk_en) begin
      if (fall_edge) begin
        tmo_nxt = '0;
        unique case (state)
          IDLE: begin
            if (!data_s2) begin
              state_nxt   = DATA;
              bit_cnt_nxt = '0;
            end
          end
          DATA: begin
            shift_nxt[bit_cnt[2:0]] = data_s2;
            if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
              bit_cnt_nxt = BIT_CNT_W'(DATA_BITS);
              state_nxt   = PARITY;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            par_nxt   = data_s2;
            state_nxt = STOP;
          end
          STOP: begin
            state_nxt = IDLE;
            if (data_s2 && ((^shift_q) ^ par_q)) begin
              byte_ok_nxt = 1'b1;
            end else begin
              error_nxt    = 1'b1;
              ext_pend_nxt = 1'b0;
              brk_pend_nxt = 1'b0;
            end
          end
        endcase
      end else if (state == IDLE) begin
        tmo_nxt = '0;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_nxt    = IDLE;
        bit_cnt_nxt  = '0;
        tmo_nxt      = '0;
        error_nxt    = 1'b1;
        ext_pend_nxt = 1'b0;
        brk_pend_nxt = 1'b0;
      end else begin
        tmo_nxt = tmo_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: table of frames with a scoreboard of
// expected scan codes, plus glitch, timeout and mid-frame reset sequences.
module tb_ps2_receiver;

  logic       clk;
  logic       RESET;
  logic       clk_en;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] code;
  logic       released;
  logic       extended;
  logic       valid;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;

  logic [9:0] exp_q[$];

  logic [7:0] m_code;
  logic       m_rel;
  logic       m_ext;

  typedef struct packed {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_code;
    logic       exp_rel;
    logic       exp_ext;
  } vec_t;

  vec_t vecs[12];

  ps2_receiver dut (
    .clk      (clk),
    .RESET    (RESET),
    .clk_en   (clk_en),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .code     (code),
    .released (released),
    .extended (extended),
    .valid    (valid),
    .error    (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clk_en high for one rising edge out of every four
  initial begin
    clk_en = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest expected code.
  always @(negedge clk) begin
    logic [9:0] e;
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(code), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_code", 32'(code), 32'(e[9:2]));
        check("sb_released", 32'(released), 32'(e[1]));
        check("sb_extended", 32'(extended), 32'(e[0]));
        check("error_with_valid", 32'(error), 32'h0);
      end
    end
    if (error) n_err++;
  end

  task automatic samples(input int n);
    repeat (n) begin
      do @(posedge clk); while (clk_en !== 1'b1);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int nbits, input int glitch_at);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = bits[i];
      samples(3);
      if (i == glitch_at) begin
        PS2_CLK = 1'b0;
        samples(1);
        PS2_CLK = 1'b1;
        samples(4);
      end
      PS2_CLK = 1'b0;
      samples(6);
      PS2_CLK = 1'b1;
      samples(3);
    end
    PS2_DATA = 1'b1;
  endtask

  task automatic expect_code(input logic [7:0] c, input logic r, input logic x);
    exp_q.push_back({c, r, x});
    m_code = c;
    m_rel  = r;
    m_ext  = x;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_code"}, 32'(code), 32'(m_code));
    check({tag, "_released"}, 32'(released), 32'(m_rel));
    check({tag, "_extended"}, 32'(extended), 32'(m_ext));
  endtask

  initial begin
    int v0, e0, waited;

    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b1, 1'b0};
    vecs[3]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0};
    vecs[4]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 1'b1, 1'b1};
    vecs[7]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0};
    vecs[11] = '{8'h29, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

    m_code   = 8'h00;
    m_rel    = 1'b0;
    m_ext    = 1'b0;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    RESET    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_code", 32'(code), 32'h0);
    check("reset_flags", 32'({released, extended, valid, error}), 32'h0);
    RESET = 1'b0;
    samples(10);
    check("idle_no_pulse", 32'(n_valid + n_err), 32'h0);

    for (int i = 0; i < 12; i++) begin
      v0 = n_valid;
      e0 = n_err;
      if (vecs[i].exp_valid)
        expect_code(vecs[i].exp_code, vecs[i].exp_rel, vecs[i].exp_ext);
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 11, -1);
      samples(4);
      check($sformatf("vec%0d_valid_cnt", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_error_cnt", i), 32'(n_err - e0), 32'(vecs[i].exp_err));
      check_model($sformatf("vec%0d", i));
    end

    // One-sample glitch on PS2_CLK in mid-frame must be filtered out
    v0 = n_valid;
    e0 = n_err;
    expect_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 11, 4);
    samples(4);
    check("glitch_valid_cnt", 32'(n_valid - v0), 32'h1);
    check("glitch_error_cnt", 32'(n_err - e0), 32'h0);
    check_model("glitch");

    // Partial frame then a silent bus: a single timeout error after ~TIMEOUT samples
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h00, 1'b0, 1'b0, 4, -1);
    waited = 0;
    while (waited < 2100 && n_err == e0) begin
      samples(1);
      waited++;
    end
    check("timeout_error_cnt", 32'(n_err - e0), 32'h1);
    check("timeout_not_early", 32'(waited >= 1900 && waited <= 2010), 32'h1);
    samples(50);
    check("timeout_single_pulse", 32'(n_err - e0), 32'h1);
    check("timeout_no_valid", 32'(n_valid - v0), 32'h0);
    expect_code(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 11, -1);
    samples(4);
    check("post_timeout_valid_cnt", 32'(n_valid - v0), 32'h1);
    check_model("post_timeout");

    // Break prefix then reset after 5 data bits: everything clears, no pulses
    send_frame(8'hF0, 1'b0, 1'b0, 11, -1);
    samples(4);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h5A, 1'b0, 1'b0, 6, -1);
    RESET = 1'b1;
    #1;
    check("midreset_code", 32'(code), 32'h0);
    check("midreset_flags", 32'({released, extended, valid, error}), 32'h0);
    repeat (8) @(posedge clk);
    #1;
    RESET = 1'b0;
    m_code = 8'h00;
    m_rel  = 1'b0;
    m_ext  = 1'b0;
    samples(20);
    check("midreset_no_pulses", 32'((n_valid - v0) + (n_err - e0)), 32'h0);
    expect_code(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 11, -1);
    samples(4);
    check("post_reset_valid_cnt", 32'(n_valid - v0), 32'h1);
    check("post_reset_error_cnt", 32'(n_err - e0), 32'h0);
    check_model("post_reset");

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
